sma_update_sequencer: RTL and testbench
=======================================

Name: sma_update_sequencer

Overview:
- Sequences each incoming per-stock price update through the shared SMA price buffer RAM (BUFFER_SIZE slots per stock, stock-major layout).
- Per update: read the price being evicted, write the new price into the same slot, update the per-stock running sum, emit the SMA.
- Sits between the order-book price feed and the buffer RAM. It is the only master of the RAM ports and owns all per-stock write indices, fill counts and sums.

Parameters:
- BUFFER_SIZE, 64: window length per stock. Power of 2 required; the SMA is a right shift by SHIFT = $clog2(BUFFER_SIZE).
- NUM_STOCKS, 4: number of independent stocks. Power of 2 required.
- PRICE_WIDTH, 32: unsigned price width.
- ADDR_WIDTH, $clog2(BUFFER_SIZE*NUM_STOCKS): RAM address width (localparam).
- SID_WIDTH, $clog2(NUM_STOCKS): stock id width (localparam).
- SUM_WIDTH, PRICE_WIDTH+SHIFT: running-sum width (localparam). Cannot overflow.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous reset, active-low
- i_valid  in  1  price update request
- o_ready  out  1  sequencer can accept an update
- i_stock_id  in  SID_WIDTH  stock of the update
- i_price  in  PRICE_WIDTH  new price
- o_mem_rd_en  out  1  RAM read request
- o_mem_rd_addr  out  ADDR_WIDTH  RAM read address
- i_mem_rd_data  in  PRICE_WIDTH  read data, valid the cycle after an accepted read
- o_mem_wr_en  out  1  RAM write strobe
- o_mem_wr_addr  out  ADDR_WIDTH  RAM write address
- o_mem_wr_data  out  PRICE_WIDTH  RAM write data
- i_mem_busy  in  1  RAM stall; a read or write is accepted only when low
- o_sma_valid  out  1  one-cycle result pulse
- o_sma_stock_id  out  SID_WIDTH  stock of the result
- o_sma  out  PRICE_WIDTH  updated sum >> SHIFT
- o_sma_full  out  1  window for that stock complete (BUFFER_SIZE samples)

Behaviour:
- Per-stock state:
  - idx[s]: 0..BUFFER_SIZE-1, wraps.
  - cnt[s]: 0..BUFFER_SIZE, saturates.
  - sum[s]: SUM_WIDTH bits.
  - full[s] = (cnt[s]==BUFFER_SIZE).
- Slot address: s*BUFFER_SIZE + idx[s].
- Reset clears all per-stock state and returns the FSM to IDLE. All outputs reset to 0, except o_ready, which is 1 in IDLE after reset.
- Reset mid-operation aborts the update: no write is issued and no result is emitted.
- FSM states:
  - IDLE: o_ready=1. On i_valid&&o_ready, latch stock id and price, go to RD.
  - RD: if full[s], assert o_mem_rd_en with rd_addr = slot. Hold while i_mem_busy=1; go to WAIT on the cycle it is low. If !full[s], no read; go to WAIT unconditionally.
  - WAIT: old = full[s] ? i_mem_rd_data : 0, registered. Go to UPD.
  - UPD: assert o_mem_wr_en, wr_addr = slot, wr_data = latched price. Hold while i_mem_busy=1. On acceptance:
    - sum[s] <= sum[s] - old + price;
    - idx[s] <= idx[s]+1 mod BUFFER_SIZE;
    - cnt[s] <= min(cnt[s]+1, BUFFER_SIZE);
    - go to OUT.
  - OUT: o_sma_valid=1 for exactly one cycle. o_sma = new sum >> SHIFT (low PRICE_WIDTH bits), o_sma_full = new full[s], o_sma_stock_id = s. Go to IDLE.
- o_ready=0 in every state except IDLE; requests presented then are ignored (requester holds i_valid).
- Latency with no stalls:
  - handshake at cycle 0; RD cycle 1, WAIT cycle 2, UPD (write) cycle 3, o_sma_valid cycle 4;
  - o_ready high again at cycle 5;
  - each busy cycle in RD or UPD adds one cycle.
- Latency is identical for full and non-full stocks.
- rd_en, wr_en, addresses and data stay stable while stalled. rd_en and wr_en are never high in the same cycle.
- full[s] first becomes 1 on the BUFFER_SIZE-th write. The (BUFFER_SIZE+1)-th update is the first to read and evict; it evicts slot idx=0.
- Stocks are fully independent; only the stock being updated changes state.
- o_sma/o_sma_stock_id/o_sma_full hold their last value when o_sma_valid=0.

Test Plan:
- Reset, then idle 10 cycles -> o_ready=1; rd_en, wr_en, o_sma_valid, o_sma all 0.
- Stock 2, price 100, no busy -> no rd_en; wr_en at cycle 3 with addr 128, data 100; cycle 4: o_sma_valid=1, o_sma=1, o_sma_full=0, o_sma_stock_id=2.
- Stock 0, 64 updates of price 64:
  - writes go to addr 0..63;
  - 63rd result: o_sma=63, full=0;
  - 64th result: o_sma=64, full=1.
- 65th update to stock 0, price 128, RAM returns 64:
  - rd_en with addr 0, then wr_en with addr 0, data 128;
  - result o_sma=65 (sum 4160), full=1.
- i_mem_busy=1 for 3 cycles in RD and 2 cycles in UPD:
  - rd_en held at constant addr, then wr_en held at constant addr and data;
  - o_sma_valid at cycle 9;
  - i_valid asserted during the operation is not accepted until IDLE.
- Interleaved stocks 1,3,1 at prices 10,20,30 -> addrs 64, 192, 65; stock-3 state unaffected by stock 1.
- Reset asserted during UPD -> no wr_en, no o_sma_valid; next stock-1 write goes to addr 64 with full=0.

Source files
------------

// File: rtl/sma_update_sequencer.sv
// Per-stock SMA update sequencer: evicts the oldest price from the shared
// window RAM, writes the new one, and keeps per-stock running sums.
module sma_update_sequencer #(
   parameter int BUFFER_SIZE = 64,
   parameter int NUM_STOCKS  = 4,
   parameter int PRICE_WIDTH = 32,
   localparam int SHIFT      = $clog2(BUFFER_SIZE),
   localparam int ADDR_WIDTH = $clog2(BUFFER_SIZE * NUM_STOCKS),
   localparam int SID_WIDTH  = $clog2(NUM_STOCKS),
   localparam int SUM_WIDTH  = PRICE_WIDTH + SHIFT
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [SID_WIDTH-1:0]   i_stock_id,
   input  logic [PRICE_WIDTH-1:0] i_price,
   output logic                   o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]  o_mem_rd_addr,
   input  logic [PRICE_WIDTH-1:0] i_mem_rd_data,
   output logic                   o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]  o_mem_wr_addr,
   output logic [PRICE_WIDTH-1:0] o_mem_wr_data,
   input  logic                   i_mem_busy,
   output logic                   o_sma_valid,
   output logic [SID_WIDTH-1:0]   o_sma_stock_id,
   output logic [PRICE_WIDTH-1:0] o_sma,
   output logic                   o_sma_full
);

   localparam int CW = $clog2(BUFFER_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      UPD,
      OUT
   } state_t;

   state_t                 state;
   logic [SHIFT-1:0]       idx [NUM_STOCKS];
   logic [CW-1:0]          cnt [NUM_STOCKS];
   logic [SUM_WIDTH-1:0]   sum [NUM_STOCKS];
   logic [SID_WIDTH-1:0]   sid_q;
   logic [PRICE_WIDTH-1:0] price_q;
   logic [PRICE_WIDTH-1:0] old_q;

   logic                   full_in;
   logic                   full_cur;
   logic [ADDR_WIDTH-1:0]  slot_in;
   logic [ADDR_WIDTH-1:0]  slot_cur;
   logic [CW-1:0]          new_cnt;
   logic [SUM_WIDTH-1:0]   new_sum;

   // Power-of-2 sizing makes the slot address a simple concatenation.
   assign full_in  = (cnt[i_stock_id] == CW'(BUFFER_SIZE));
   assign full_cur = (cnt[sid_q] == CW'(BUFFER_SIZE));
   assign slot_in  = {i_stock_id, idx[i_stock_id]};
   assign slot_cur = {sid_q, idx[sid_q]};
   assign new_cnt  = full_cur ? cnt[sid_q] : cnt[sid_q] + CW'(1);
   assign new_sum  = sum[sid_q] - SUM_WIDTH'(old_q)
                   + SUM_WIDTH'(price_q);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state          <= IDLE;
         o_ready        <= 1'b1;
         o_mem_rd_en    <= 1'b0;
         o_mem_rd_addr  <= '0;
         o_mem_wr_en    <= 1'b0;
         o_mem_wr_addr  <= '0;
         o_mem_wr_data  <= '0;
         o_sma_valid    <= 1'b0;
         o_sma_stock_id <= '0;
         o_sma          <= '0;
         o_sma_full     <= 1'b0;
         sid_q          <= '0;
         price_q        <= '0;
         old_q          <= '0;
         for (int s = 0; s < NUM_STOCKS; s++) begin
            idx[s] <= '0;
            cnt[s] <= '0;
            sum[s] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  sid_q         <= i_stock_id;
                  price_q       <= i_price;
                  o_ready       <= 1'b0;
                  o_mem_rd_en   <= full_in;
                  o_mem_rd_addr <= slot_in;
                  state         <= RD;
               end
            end
            RD: begin
               if (!(o_mem_rd_en && i_mem_busy)) begin
                  o_mem_rd_en <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               old_q         <= full_cur ? i_mem_rd_data : '0;
               o_mem_wr_en   <= 1'b1;
               o_mem_wr_addr <= slot_cur;
               o_mem_wr_data <= price_q;
               state         <= UPD;
            end
            UPD: begin
               if (!i_mem_busy) begin
                  o_mem_wr_en    <= 1'b0;
                  sum[sid_q]     <= new_sum;
                  idx[sid_q]     <= idx[sid_q] + SHIFT'(1);
                  cnt[sid_q]     <= new_cnt;
                  o_sma_valid    <= 1'b1;
                  o_sma          <= new_sum[SUM_WIDTH-1:SHIFT];
                  o_sma_full     <= (new_cnt == CW'(BUFFER_SIZE));
                  o_sma_stock_id <= sid_q;
                  state          <= OUT;
               end
            end
            OUT: begin
               o_sma_valid <= 1'b0;
               o_ready     <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sma_update_sequencer.sv
// Bench for sma_update_sequencer: RAM model plus window-queue reference
// model; scenario tasks compare observed RAM traffic and results.
module tb_sma_update_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        o_ready;
   logic [1:0]  stock = '0;
   logic [31:0] price = '0;
   logic        o_mem_rd_en;
   logic [7:0]  o_mem_rd_addr;
   logic [31:0] rd_data = '0;
   logic        o_mem_wr_en;
   logic [7:0]  o_mem_wr_addr;
   logic [31:0] o_mem_wr_data;
   logic        busy = 1'b0;
   logic        o_sma_valid;
   logic [1:0]  o_sma_stock_id;
   logic [31:0] o_sma;
   logic        o_sma_full;

   int tests = 0;
   int fails = 0;
   int wr_acc = 0;

   logic [31:0] mem [256];
   logic [31:0] win [4][$];
   int          total [4];

   always #5 clk = ~clk;

   sma_update_sequencer dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_valid        (valid),
      .o_ready        (o_ready),
      .i_stock_id     (stock),
      .i_price        (price),
      .o_mem_rd_en    (o_mem_rd_en),
      .o_mem_rd_addr  (o_mem_rd_addr),
      .i_mem_rd_data  (rd_data),
      .o_mem_wr_en    (o_mem_wr_en),
      .o_mem_wr_addr  (o_mem_wr_addr),
      .o_mem_wr_data  (o_mem_wr_data),
      .i_mem_busy     (busy),
      .o_sma_valid    (o_sma_valid),
      .o_sma_stock_id (o_sma_stock_id),
      .o_sma          (o_sma),
      .o_sma_full     (o_sma_full)
   );

   always @(posedge clk) begin
      if (o_mem_rd_en && !busy) rd_data <= mem[o_mem_rd_addr];
      if (o_mem_wr_en && !busy) begin
         mem[o_mem_wr_addr] <= o_mem_wr_data;
         wr_acc <= wr_acc + 1;
      end
   end

   typedef struct {
      int          rd_cnt;
      int          rd_addr;
      int          rcyc;
      bit          rd_stable;
      int          wr_cnt;
      int          wr_addr;
      logic [31:0] wr_data;
      int          wcyc;
      bit          wr_stable;
      bit          overlap;
      int          vcnt;
      int          vcyc;
      logic [31:0] sma;
      bit          full;
      int          sid;
      int          rdy_cyc;
   } obs_t;

   function automatic void model_reset();
      for (int s = 0; s < 4; s++) begin
         win[s].delete();
         total[s] = 0;
      end
   endfunction

   // Window as a queue: evict front when 64 deep, SMA = sum/64.
   function automatic void model_step(input int s, input logic [31:0] p,
                                      output int addr, output bit rd,
                                      output logic [31:0] sma, output bit full);
      longint unsigned acc = 0;
      addr = s * 64 + (total[s] % 64);
      rd = (win[s].size() == 64);
      if (rd) void'(win[s].pop_front());
      win[s].push_back(p);
      total[s]++;
      for (int k = 0; k < win[s].size(); k++) acc += longint'(win[s][k]);
      sma = 32'(acc / 64);
      full = (win[s].size() == 64);
   endfunction

   task automatic do_update(input int sid, input logic [31:0] p,
                            input int brd, input int bupd, input bit hold,
                            output obs_t o);
      int brl = brd;
      int bul = bupd;
      int waitc = 0;
      o = '{default: 0};
      o.rd_stable = 1; o.wr_stable = 1;
      o.rcyc = -1; o.wcyc = -1; o.vcyc = -1; o.rdy_cyc = -1;
      @(negedge clk);
      while (!o_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      valid = 1'b1; stock = 2'(sid); price = p; busy = 1'b0;
      @(posedge clk);
      for (int c = 1; c < 60; c++) begin
         @(negedge clk);
         if (hold) price = $urandom; else valid = 1'b0;
         if (o_ready) begin
            o.rdy_cyc = c; valid = 1'b0; busy = 1'b0;
            break;
         end
         if (o_mem_rd_en) begin
            if (o.rd_cnt == 0) begin
               o.rd_addr = int'(o_mem_rd_addr); o.rcyc = c;
            end else if (int'(o_mem_rd_addr) != o.rd_addr) o.rd_stable = 0;
            o.rd_cnt++;
         end
         if (o_mem_wr_en) begin
            if (o.wr_cnt == 0) begin
               o.wr_addr = int'(o_mem_wr_addr);
               o.wr_data = o_mem_wr_data; o.wcyc = c;
            end else if (int'(o_mem_wr_addr) != o.wr_addr ||
                         o_mem_wr_data !== o.wr_data) o.wr_stable = 0;
            o.wr_cnt++;
         end
         if (o_mem_rd_en && o_mem_wr_en) o.overlap = 1;
         if (o_sma_valid) begin
            o.vcnt++; o.vcyc = c; o.sma = o_sma;
            o.full = o_sma_full; o.sid = int'(o_sma_stock_id);
         end
         if (o_mem_rd_en && brl > 0) begin busy = 1'b1; brl--; end
         else if (o_mem_wr_en && bul > 0) begin busy = 1'b1; bul--; end
         else busy = 1'b0;
      end
      tests++;
      if (o.rdy_cyc < 0) begin
         fails++;
         $display("FAIL timeout: o_ready not back, sid %0d rdy_cyc %0d want >0", sid, o.rdy_cyc);
      end
   endtask

   task automatic test_reset();
      bit bad = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (10) begin
         @(negedge clk);
         if (o_mem_rd_en || o_mem_wr_en || o_sma_valid) bad = 1;
      end
      tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset o_ready got %b want 1", o_ready); end
      tests++; if (o_mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset rd_en got %b want 0", o_mem_rd_en); end
      tests++; if (o_mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset wr_en got %b want 0", o_mem_wr_en); end
      tests++; if (o_sma_valid !== 1'b0) begin fails++; $display("FAIL reset sma_valid got %b want 0", o_sma_valid); end
      tests++; if (o_sma !== 32'd0) begin fails++; $display("FAIL reset sma got %0d want 0", o_sma); end
      tests++; if (o_sma_full !== 1'b0) begin fails++; $display("FAIL reset sma_full got %b want 0", o_sma_full); end
      tests++; if (bad) begin fails++; $display("FAIL reset idle_strobes got 1 want 0"); end
   endtask

   task automatic test_single();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      model_step(2, 100, ea, er, es, ef);
      do_update(2, 100, 0, 0, 0, o);
      tests++; if (o.rd_cnt != 0) begin fails++; $display("FAIL single rd_cnt got %0d want 0", o.rd_cnt); end
      tests++; if (o.wcyc != 3) begin fails++; $display("FAIL single wr_cycle got %0d want 3", o.wcyc); end
      tests++; if (o.wr_addr != 128) begin fails++; $display("FAIL single wr_addr got %0d want 128", o.wr_addr); end
      tests++; if (o.wr_data !== 32'd100) begin fails++; $display("FAIL single wr_data got %0d want 100", o.wr_data); end
      tests++; if (o.vcyc != 4 || o.vcnt != 1) begin fails++; $display("FAIL single valid_cycle got %0d/%0d want 4/1", o.vcyc, o.vcnt); end
      tests++; if (o.sma !== 32'd1 || o.full || o.sid != 2) begin fails++; $display("FAIL single result got sma %0d full %0d sid %0d want 1 0 2", o.sma, o.full, o.sid); end
      tests++; if (o.rdy_cyc != 5) begin fails++; $display("FAIL single ready_cycle got %0d want 5", o.rdy_cyc); end
   endtask

   task automatic test_fill();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      for (int i = 0; i < 64; i++) begin
         model_step(0, 64, ea, er, es, ef);
         do_update(0, 64, 0, 0, 0, o);
         tests++; if (o.wr_addr != i || o.wr_addr != ea || o.rd_cnt != 0) begin fails++; $display("FAIL fill wr_addr[%0d] got %0d rd %0d want %0d rd 0", i, o.wr_addr, o.rd_cnt, i); end
         tests++; if (o.sma !== es || o.full != ef) begin fails++; $display("FAIL fill result[%0d] got %0d/%0d want %0d/%0d", i, o.sma, o.full, es, ef); end
         if (i == 62) begin
            tests++; if (o.sma !== 32'd63 || o.full) begin fails++; $display("FAIL fill 63rd got %0d/%0d want 63/0", o.sma, o.full); end
         end
         if (i == 63) begin
            tests++; if (o.sma !== 32'd64 || !o.full) begin fails++; $display("FAIL fill 64th got %0d/%0d want 64/1", o.sma, o.full); end
         end
      end
   endtask

   task automatic test_evict();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      model_step(0, 128, ea, er, es, ef);
      do_update(0, 128, 0, 0, 0, o);
      tests++; if (o.rd_cnt != 1 || o.rd_addr != 0 || o.rcyc != 1) begin fails++; $display("FAIL evict read got cnt %0d addr %0d cyc %0d want 1 0 1", o.rd_cnt, o.rd_addr, o.rcyc); end
      tests++; if (o.wr_addr != 0 || o.wr_data !== 32'd128 || o.wcyc != 3) begin fails++; $display("FAIL evict write got addr %0d data %0d cyc %0d want 0 128 3", o.wr_addr, o.wr_data, o.wcyc); end
      tests++; if (o.sma !== 32'd65 || !o.full || o.sma !== es) begin fails++; $display("FAIL evict result got %0d/%0d want 65/1", o.sma, o.full); end
      tests++; if (o.vcyc != 4 || o.rdy_cyc != 5 || o.overlap) begin fails++; $display("FAIL evict latency got %0d/%0d ov %0d want 4/5 ov 0", o.vcyc, o.rdy_cyc, o.overlap); end
   endtask

   task automatic test_stall();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      logic [31:0] p = $urandom;
      model_step(0, p, ea, er, es, ef);
      do_update(0, p, 3, 2, 1, o);
      tests++; if (o.rd_cnt != 4 || !o.rd_stable || o.rd_addr != ea) begin fails++; $display("FAIL stall read got cnt %0d st %0d addr %0d want 4 1 %0d", o.rd_cnt, o.rd_stable, o.rd_addr, ea); end
      tests++; if (o.wr_cnt != 3 || !o.wr_stable || o.wr_addr != ea || o.wr_data !== p) begin fails++; $display("FAIL stall write got cnt %0d st %0d addr %0d data %0h want 3 1 %0d %0h", o.wr_cnt, o.wr_stable, o.wr_addr, o.wr_data, ea, p); end
      tests++; if (o.vcyc != 9 || o.vcnt != 1) begin fails++; $display("FAIL stall valid_cycle got %0d/%0d want 9/1", o.vcyc, o.vcnt); end
      tests++; if (o.rdy_cyc != 10 || o.overlap) begin fails++; $display("FAIL stall ready_cycle got %0d ov %0d want 10 ov 0", o.rdy_cyc, o.overlap); end
      tests++; if (o.sma !== es || !o.full) begin fails++; $display("FAIL stall result got %0d/%0d want %0d/1", o.sma, o.full, es); end
   endtask

   task automatic test_interleave();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      int sids [4] = '{1, 3, 1, 3};
      int prc [4] = '{10, 20, 30, 40};
      int addrs [4] = '{64, 192, 65, 193};
      for (int i = 0; i < 4; i++) begin
         model_step(sids[i], 32'(prc[i]), ea, er, es, ef);
         do_update(sids[i], 32'(prc[i]), 0, 0, 0, o);
         tests++; if (o.wr_addr != addrs[i] || o.rd_cnt != 0) begin fails++; $display("FAIL interleave addr[%0d] got %0d rd %0d want %0d", i, o.wr_addr, o.rd_cnt, addrs[i]); end
         tests++; if (o.sid != sids[i] || o.sma !== es || o.full) begin fails++; $display("FAIL interleave result[%0d] got sid %0d sma %0d full %0d want %0d %0d 0", i, o.sid, o.sma, o.full, sids[i], es); end
      end
   endtask

   task automatic test_random();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      int s; int br; int bu; logic [31:0] p;
      for (int i = 0; i < 120; i++) begin
         s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
         p = $urandom;
         br = int'($urandom_range(0, 2));
         bu = int'($urandom_range(0, 2));
         model_step(s, p, ea, er, es, ef);
         do_update(s, p, br, bu, bit'($urandom_range(0, 1)), o);
         tests++; if (o.rd_cnt != (er ? br + 1 : 0) || (er && (o.rd_addr != ea || !o.rd_stable))) begin fails++; $display("FAIL random read[%0d] got cnt %0d addr %0d want %0d %0d", i, o.rd_cnt, o.rd_addr, er ? br + 1 : 0, ea); end
         tests++; if (o.wr_cnt != bu + 1 || o.wr_addr != ea || o.wr_data !== p || !o.wr_stable) begin fails++; $display("FAIL random write[%0d] got cnt %0d addr %0d data %0h want %0d %0d %0h", i, o.wr_cnt, o.wr_addr, o.wr_data, bu + 1, ea, p); end
         tests++; if (o.sma !== es || o.full != ef || o.sid != s || o.vcnt != 1) begin fails++; $display("FAIL random result[%0d] got %0d/%0d sid %0d want %0d/%0d sid %0d", i, o.sma, o.full, o.sid, es, ef, s); end
         tests++; if (o.vcyc != 4 + (er ? br : 0) + bu || o.overlap) begin fails++; $display("FAIL random latency[%0d] got %0d ov %0d want %0d", i, o.vcyc, o.overlap, 4 + (er ? br : 0) + bu); end
      end
   endtask

   task automatic test_reset_mid();
      obs_t o; int ea; bit er; logic [31:0] es; bit ef;
      bit seen = 0; bit bad = 0; int acc0;
      @(negedge clk);
      valid = 1'b1; stock = 2'd1; price = 32'd77; busy = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         valid = 1'b0;
         if (o_mem_wr_en) begin seen = 1; break; end
      end
      tests++; if (!seen) begin fails++; $display("FAIL reset_mid reach_upd got 0 want 1"); end
      busy = 1'b1;
      acc0 = wr_acc;
      rst_n = 1'b0;
      @(negedge clk);
      tests++; if (o_mem_wr_en !== 1'b0 || o_sma_valid !== 1'b0 || o_ready !== 1'b1) begin fails++; $display("FAIL reset_mid outputs got wr %b v %b rdy %b want 0 0 1", o_mem_wr_en, o_sma_valid, o_ready); end
      rst_n = 1'b1; busy = 1'b0;
      model_reset();
      repeat (6) begin
         @(negedge clk);
         if (o_mem_wr_en || o_sma_valid) bad = 1;
      end
      tests++; if (bad || wr_acc != acc0) begin fails++; $display("FAIL reset_mid aborted got strobe %0d writes %0d want 0 %0d", bad, wr_acc, acc0); end
      model_step(1, 55, ea, er, es, ef);
      do_update(1, 55, 0, 0, 0, o);
      tests++; if (o.wr_addr != 64 || o.full || o.rd_cnt != 0 || o.sma !== es) begin fails++; $display("FAIL reset_mid next got addr %0d full %0d rd %0d want 64 0 0", o.wr_addr, o.full, o.rd_cnt); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_evict();
      test_stall();
      test_interleave();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
